ahb_apb_bridge: RTL and testbench
=================================

Name: ahb_apb_bridge

Overview:
- Single-slave AHB-Lite to APB4 bridge.
- Converts each selected AHB transfer into one APB SETUP/ACCESS sequence.
- Stalls the AHB data phase with HREADYOUT until the APB slave completes, then returns read data and an OKAY or ERROR response.
- Sits between an AHB master/interconnect and an APB peripheral segment clocked from HCLK, qualified by PCLKEN.

Parameters:
- ADDRWIDTH, 16: width of HADDR/PADDR.
- WRITE_REG, 1: 1 = PWDATA registered from HWDATA (adds one cycle); 0 = PWDATA driven combinationally from HWDATA.
- READ_REG, 1: 1 = HRDATA/response registered (adds one cycle); 0 = HRDATA = PRDATA, and completion is returned in the same cycle.

Ports:
- HCLK in 1: clock, rising edge.
- HRESET in 1: reset, asynchronous, active-high.
- PCLKEN in 1: APB clock enable; APB state advances only when it is 1.
- HSEL in 1: slave select.
- HADDR in ADDRWIDTH: AHB address.
- HTRANS in 2: transfer type.
- HSIZE in 3: transfer size.
- HPROT in 4: protection.
- HWRITE in 1: 1 = write.
- HREADY in 1: bus ready (address-phase qualifier).
- HWDATA in 32: write data.
- HREADYOUT out 1: data-phase ready.
- HRDATA out 32: read data.
- HRESP out 1: 0 = OKAY, 1 = ERROR.
- PADDR out ADDRWIDTH: APB address, word aligned.
- PSEL out 1: APB select.
- PENABLE out 1: APB enable.
- PWRITE out 1: APB direction.
- PWDATA out 32: APB write data.
- PSTRB out 4: byte strobes.
- PPROT out 3: APB protection.
- PRDATA in 32: APB read data.
- PREADY in 1: APB ready.
- PSLVERR in 1: APB error.

Behaviour:
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0, PPROT=0. State = IDLE.
- Reset is honoured in any state and aborts an in-flight transfer immediately.
- Accept: HSEL & HTRANS[1] & HREADY at a rising edge, in IDLE or on the completion edge.
- On accept, capture:
  - PADDR = {HADDR[ADDRWIDTH-1:2], 2'b00}
  - PWRITE = HWRITE
  - PPROT = {~HPROT[0], 1'b0, HPROT[1]}
  - PSTRB (reads = 0000):
    - Byte: 0001 << HADDR[1:0].
    - Halfword: 0011 if HADDR[1]=0, else 1100.
    - Word or larger (larger treated as word): 1111.
- IDLE/BUSY or unselected transfers get a zero-wait OKAY (HREADYOUT=1, HRESP=0).
- States:
  - IDLE: HREADYOUT=1. Go to WAIT on accept.
  - WAIT: HREADYOUT=0.
    - If WRITE_REG=1 and write: latch HWDATA into PWDATA at the end of this cycle.
    - Go to SETUP at the next edge where PCLKEN=1 (and WAIT has lasted at least one cycle).
    - If WRITE_REG=0: WAIT lasts only until the first PCLKEN edge, and PWDATA follows HWDATA.
  - SETUP: PSEL=1, PENABLE=0. Go to ACCESS when PCLKEN=1.
  - ACCESS: PSEL=1, PENABLE=1. Completion = PREADY & PCLKEN; hold while PREADY=0.
    - On completion with PSLVERR=0: go to DONE (READ_REG=1), or assert HREADYOUT=1 in this cycle with HRDATA=PRDATA (READ_REG=0).
    - On completion with PSLVERR=1: go to ERR1.
  - DONE: HREADYOUT=1, HRESP=0, HRDATA = PRDATA registered at completion. A new transfer may be accepted in this cycle.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1, then IDLE or WAIT if a new transfer is accepted.
- Zero-wait APB latency with defaults and PCLKEN=1:
  - Address phase at cycle 0.
  - WAIT at cycle 1, SETUP at cycle 2, ACCESS at cycle 3.
  - HREADYOUT=1 at cycle 4.
  - Each PREADY-low cycle adds one cycle.
- PSEL/PENABLE are registered, glitch-free, and never asserted outside SETUP/ACCESS.
- PADDR, PWRITE, PSTRB and PPROT are stable from SETUP through completion.
- HRDATA holds its last value (READ_REG=1); read data on writes is don't-care.

Optional Feature:
- Macro: AHB2APB_APBACTIVE_EN.
- When defined: adds output APBACTIVE (1 bit), high whenever the state is not IDLE or an accept is pending. It is used for APB clock gating, with reset value 0.
- When undefined: the port and its logic are absent, and behaviour is otherwise identical.

Test Plan:
- Word write HADDR=0x0010, HWDATA=0xDEADBEEF, PREADY=1 -> PSEL in cycle 2 and PENABLE in cycle 3, with PADDR=0x0010, PWRITE=1, PSTRB=1111, PWDATA=0xDEADBEEF; HREADYOUT low for 3 cycles, HRESP=0.
- Word read of 0x0010 with slave PRDATA=0xDEADBEEF -> PSTRB=0000; HRDATA=0xDEADBEEF when HREADYOUT returns 1.
- Byte write HADDR=0x0013 (HSIZE=0) and halfword write HADDR=0x0016 (HSIZE=1) -> PADDR=0x0010, PSTRB=1000; then PADDR=0x0014, PSTRB=1100.
- PREADY held low 2 ACCESS cycles, then PSLVERR=1 with PREADY -> PENABLE stays high for 3 cycles; ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1).
- PCLKEN asserted every other cycle during a write -> SETUP/ACCESS advance only on PCLKEN=1 edges; data/strobe stable throughout.
- HRESET pulsed while in ACCESS -> PSEL=PENABLE=0 and HREADYOUT=1 immediately; the next accepted write completes normally.

Source files
------------

// File: rtl/ahb_apb_bridge.sv
// ---------------------------------------------------------------------------
// ahb_apb_bridge
//   Single-slave AHB-Lite to APB4 bridge. Each selected AHB transfer becomes
//   one APB SETUP/ACCESS sequence. The AHB data phase is stalled through
//   HREADYOUT until the APB slave completes. The APB side runs on HCLK and is
//   qualified by PCLKEN.
//
//   Parameters
//     ADDRWIDTH : HADDR/PADDR width
//     WRITE_REG : 1 = PWDATA registered from HWDATA, 0 = PWDATA = HWDATA
//     READ_REG  : 1 = HRDATA/response registered (DONE state),
//                 0 = HRDATA = PRDATA, completion returned in ACCESS
//
//   Ports
//     HCLK, HRESET (async, active high)
//     PCLKEN                              : APB clock enable
//     HSEL/HADDR/HTRANS/HSIZE/HPROT/HWRITE/HREADY/HWDATA : AHB inputs
//     HREADYOUT/HRDATA/HRESP              : AHB data-phase response
//     PADDR/PSEL/PENABLE/PWRITE/PWDATA/PSTRB/PPROT       : APB request
//     PRDATA/PREADY/PSLVERR               : APB completion
//
//   Optional feature (macro AHB2APB_APBACTIVE_EN)
//     Adds output APBACTIVE: high when the bridge is not idle or an accept
//     is pending. Intended for gating the APB clock.
// ---------------------------------------------------------------------------
module ahb_apb_bridge #(
    parameter int ADDRWIDTH = 16,
    parameter bit WRITE_REG = 1'b1,
    parameter bit READ_REG  = 1'b1
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic                 PCLKEN,
    input  logic                 HSEL,
    input  logic [ADDRWIDTH-1:0] HADDR,
    input  logic [1:0]           HTRANS,
    input  logic [2:0]           HSIZE,
    input  logic [3:0]           HPROT,
    input  logic                 HWRITE,
    input  logic                 HREADY,
    input  logic [31:0]          HWDATA,
`ifdef AHB2APB_APBACTIVE_EN
    output logic                 APBACTIVE,
`endif
    output logic                 HREADYOUT,
    output logic [31:0]          HRDATA,
    output logic                 HRESP,
    output logic [ADDRWIDTH-1:0] PADDR,
    output logic                 PSEL,
    output logic                 PENABLE,
    output logic                 PWRITE,
    output logic [31:0]          PWDATA,
    output logic [3:0]           PSTRB,
    output logic [2:0]           PPROT,
    input  logic [31:0]          PRDATA,
    input  logic                 PREADY,
    input  logic                 PSLVERR
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR1   = 3'd5,
        ST_ERR2   = 3'd6
    } state_t;

    state_t                 state_q, state_d;
    logic                   psel_q, penable_q;
    logic                   pwrite_q;
    logic [ADDRWIDTH-1:0]   paddr_q;
    logic [3:0]             pstrb_q;
    logic [2:0]             pprot_q;
    logic [31:0]            pwdata_q;
    logic [31:0]            hrdata_q;

    logic                   accept;
    logic                   load;
    logic                   hreadyout_d;
    logic                   hresp_d;
    logic                   apb_done;
    logic [3:0]             strb_nxt;

    // Transfer type bit 0 (SEQ vs NONSEQ) and HPROT[3:2] have no APB meaning.
    logic                   unused_inputs;
    assign unused_inputs = ^{HTRANS[0], HPROT[3:2]};

    assign accept   = HSEL & HTRANS[1] & HREADY;
    assign apb_done = PREADY & PCLKEN;

    // Byte strobes from size/low address; reads carry no strobes.
    always_comb begin
        strb_nxt = 4'b0000;
        if (HWRITE) begin
            case (HSIZE)
                3'b000:  strb_nxt = 4'b0001 << HADDR[1:0];
                3'b001:  strb_nxt = HADDR[1] ? 4'b1100 : 4'b0011;
                default: strb_nxt = 4'b1111;
            endcase
        end
    end

    // Next-state and AHB response decode.
    always_comb begin
        state_d     = state_q;
        load        = 1'b0;
        hreadyout_d = 1'b1;
        hresp_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_WAIT;
                    load    = 1'b1;
                end
            end
            ST_WAIT: begin
                hreadyout_d = 1'b0;
                if (PCLKEN) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                hreadyout_d = 1'b0;
                if (PCLKEN) state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                hreadyout_d = 1'b0;
                if (apb_done) begin
                    if (PSLVERR) begin
                        state_d = ST_ERR1;
                    end else if (READ_REG) begin
                        state_d = ST_DONE;
                    end else begin
                        // Unregistered response: data phase ends right here,
                        // so a pipelined address phase may be taken now.
                        hreadyout_d = 1'b1;
                        if (accept) begin
                            state_d = ST_WAIT;
                            load    = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            ST_DONE: begin
                if (accept) begin
                    state_d = ST_WAIT;
                    load    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERR1: begin
                // Two-cycle AHB error response: first cycle stalls.
                hreadyout_d = 1'b0;
                hresp_d     = 1'b1;
                state_d     = ST_ERR2;
            end
            ST_ERR2: begin
                hresp_d = 1'b1;
                if (accept) begin
                    state_d = ST_WAIT;
                    load    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q   <= ST_IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pstrb_q   <= 4'b0000;
            pprot_q   <= 3'b000;
            pwdata_q  <= '0;
            hrdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            // PSEL/PENABLE come straight from flops so they cannot glitch.
            psel_q    <= (state_d == ST_SETUP) || (state_d == ST_ACCESS);
            penable_q <= (state_d == ST_ACCESS);
            if (load) begin
                paddr_q  <= {HADDR[ADDRWIDTH-1:2], 2'b00};
                pwrite_q <= HWRITE;
                pstrb_q  <= strb_nxt;
                pprot_q  <= {~HPROT[0], 1'b0, HPROT[1]};
            end
            // HWDATA is valid during the data phase, i.e. while in WAIT.
            if (state_q == ST_WAIT && pwrite_q) begin
                pwdata_q <= HWDATA;
            end
            if (state_q == ST_ACCESS && apb_done && !pwrite_q) begin
                hrdata_q <= PRDATA;
            end
        end
    end

    assign HREADYOUT = hreadyout_d;
    assign HRESP     = hresp_d;
    assign HRDATA    = READ_REG ? hrdata_q : PRDATA;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PSTRB     = pstrb_q;
    assign PPROT     = pprot_q;
    assign PWDATA    = WRITE_REG ? pwdata_q : HWDATA;

`ifdef AHB2APB_APBACTIVE_EN
    assign APBACTIVE = (state_q != ST_IDLE) | accept;
`endif

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// ---------------------------------------------------------------------------
// tb_ahb_apb_bridge
//   Directed bench for ahb_apb_bridge (default parameters). A table of
//   single transfers with hand-computed APB request fields is applied in a
//   loop; error response, PCLKEN throttling and reset-in-ACCESS are covered
//   by hand-written cycle sequences.
// ---------------------------------------------------------------------------
module tb_ahb_apb_bridge;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        pclken;
    logic        hsel;
    logic [15:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [3:0]  hprot;
    logic        hwrite;
    logic        hready;
    logic [31:0] hwdata;
    logic        hreadyout;
    logic [31:0] hrdata;
    logic        hresp;
    logic [15:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int n_cmp = 0;
    int n_bad = 0;

    // Single slave on the bus: the interconnect's HREADY is our HREADYOUT.
    assign hready = hreadyout;

    always #5 hclk = ~hclk;

    ahb_apb_bridge dut (
        .HCLK      (hclk),
        .HRESET    (hreset),
        .PCLKEN    (pclken),
        .HSEL      (hsel),
        .HADDR     (haddr),
        .HTRANS    (htrans),
        .HSIZE     (hsize),
        .HPROT     (hprot),
        .HWRITE    (hwrite),
        .HREADY    (hready),
        .HWDATA    (hwdata),
        .HREADYOUT (hreadyout),
        .HRDATA    (hrdata),
        .HRESP     (hresp),
        .PADDR     (paddr),
        .PSEL      (psel),
        .PENABLE   (penable),
        .PWRITE    (pwrite),
        .PWDATA    (pwdata),
        .PSTRB     (pstrb),
        .PPROT     (pprot),
        .PRDATA    (prdata),
        .PREADY    (pready),
        .PSLVERR   (pslverr)
    );

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [2:0]  size;
        logic [3:0]  prot;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [15:0] e_paddr;
        logic [3:0]  e_strb;
        logic [2:0]  e_prot;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic addr_phase(input logic wr, input logic [15:0] a, input logic [2:0] sz,
                              input logic [3:0] pr);
        hsel   = 1'b1;
        htrans = 2'b10;
        hwrite = wr;
        haddr  = a;
        hsize  = sz;
        hprot  = pr;
    endtask

    task automatic bus_idle();
        hsel   = 1'b0;
        htrans = 2'b00;
    endtask

    // One transfer with PCLKEN=1 and a zero-wait slave. Called one step after
    // a rising edge with the bridge able to accept; returns in cycle 4.
    task automatic do_xfer(input string tag, input vec_t v);
        pclken  = 1'b1;
        pready  = 1'b1;
        pslverr = 1'b0;
        prdata  = v.rdata;
        chk({tag, "_c0_hready"}, 64'(hreadyout), 64'd1);
        addr_phase(v.wr, v.addr, v.size, v.prot);
        step();                                             // cycle 1: WAIT
        bus_idle();
        hwdata = v.wr ? v.wdata : 32'h0BAD_0BAD;
        chk({tag, "_c1_ctl"}, 64'({psel, penable, hreadyout}), 64'b000);
        step();                                             // cycle 2: SETUP
        chk({tag, "_c2_ctl"}, 64'({psel, penable, hreadyout}), 64'b100);
        chk({tag, "_paddr"}, 64'(paddr), 64'(v.e_paddr));
        chk({tag, "_pwrite"}, 64'(pwrite), 64'(v.wr));
        chk({tag, "_pstrb"}, 64'(pstrb), 64'(v.e_strb));
        chk({tag, "_pprot"}, 64'(pprot), 64'(v.e_prot));
        if (v.wr) chk({tag, "_pwdata"}, 64'(pwdata), 64'(v.wdata));
        step();                                             // cycle 3: ACCESS
        chk({tag, "_c3_ctl"}, 64'({psel, penable, hreadyout}), 64'b110);
        chk({tag, "_c3_hold"}, 64'({paddr, pstrb}), 64'({v.e_paddr, v.e_strb}));
        step();                                             // cycle 4: DONE
        chk({tag, "_c4_resp"}, 64'({psel, penable, hreadyout, hresp}), 64'b0010);
        if (!v.wr) chk({tag, "_hrdata"}, 64'(hrdata), 64'(v.rdata));
    endtask

    // {psel, penable, hreadyout, hresp} expected per cycle
    logic [3:0] err_exp [1:8];
    logic [3:0] clk_exp [1:7];

    initial begin
        //            wr    addr      size  prot     wdata         rdata         paddr     strb     pprot
        vecs[0] = '{1'b1, 16'h0010, 3'd2, 4'b0011, 32'hDEADBEEF, 32'h0,        16'h0010, 4'b1111, 3'b001};
        vecs[1] = '{1'b0, 16'h0010, 3'd2, 4'b0010, 32'h0,        32'hDEADBEEF, 16'h0010, 4'b0000, 3'b101};
        vecs[2] = '{1'b1, 16'h0013, 3'd0, 4'b0000, 32'h11223344, 32'h0,        16'h0010, 4'b1000, 3'b100};
        vecs[3] = '{1'b1, 16'h0016, 3'd1, 4'b0001, 32'h55667788, 32'h0,        16'h0014, 4'b1100, 3'b000};
        vecs[4] = '{1'b1, 16'h0021, 3'd0, 4'b0011, 32'hA5A5A5A5, 32'h0,        16'h0020, 4'b0010, 3'b001};
        vecs[5] = '{1'b1, 16'h0100, 3'd1, 4'b0010, 32'h0F0F0F0F, 32'h0,        16'h0100, 4'b0011, 3'b101};
        vecs[6] = '{1'b1, 16'h0ABC, 3'd3, 4'b0000, 32'h13579BDF, 32'h0,        16'h0ABC, 4'b1111, 3'b100};
        vecs[7] = '{1'b0, 16'h1235, 3'd0, 4'b0001, 32'h0,        32'h12345678, 16'h1234, 4'b0000, 3'b000};
        vecs[8] = '{1'b1, 16'hFFFF, 3'd2, 4'b0011, 32'hFEDCBA98, 32'h0,        16'hFFFC, 4'b1111, 3'b001};

        err_exp[1] = 4'b0000; err_exp[2] = 4'b1000; err_exp[3] = 4'b1100; err_exp[4] = 4'b1100;
        err_exp[5] = 4'b1100; err_exp[6] = 4'b0001; err_exp[7] = 4'b0011; err_exp[8] = 4'b0010;

        clk_exp[1] = 4'b0000; clk_exp[2] = 4'b0000; clk_exp[3] = 4'b1000; clk_exp[4] = 4'b1000;
        clk_exp[5] = 4'b1100; clk_exp[6] = 4'b1100; clk_exp[7] = 4'b0010;

        hreset = 1'b1; pclken = 1'b1; hsel = 1'b0; haddr = '0; htrans = 2'b00;
        hsize = 3'd0; hprot = 4'd0; hwrite = 1'b0; hwdata = '0;
        prdata = '0; pready = 1'b1; pslverr = 1'b0;

        // ---------------- reset values
        repeat (2) @(posedge hclk);
        #1;
        chk("rst_ctl", 64'({hreadyout, hresp, psel, penable, pwrite}), 64'b10000);
        chk("rst_hrdata", 64'(hrdata), 64'd0);
        chk("rst_paddr", 64'(paddr), 64'd0);
        chk("rst_pwdata", 64'(pwdata), 64'd0);
        chk("rst_strb_prot", 64'({pstrb, pprot}), 64'd0);
        hreset = 1'b0;
        step();

        // ---------------- table of single transfers
        for (int i = 0; i < 9; i++) begin
            do_xfer($sformatf("v%0d", i), vecs[i]);
        end

        // ---------------- PREADY low 2 cycles, then PSLVERR
        pclken = 1'b1; pready = 1'b0; pslverr = 1'b0; prdata = 32'h55AA55AA;
        addr_phase(1'b0, 16'h0030, 3'd2, 4'b0011);
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 1) bus_idle();
            if (k == 5) begin pready = 1'b1; pslverr = 1'b1; end
            if (k == 6) pslverr = 1'b0;
            chk($sformatf("err_c%0d", k), 64'({psel, penable, hreadyout, hresp}), 64'(err_exp[k]));
        end

        // ---------------- PCLKEN every other cycle during a write
        addr_phase(1'b1, 16'h0042, 3'd1, 4'b0001);
        pclken = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 1) begin
                bus_idle();
                hwdata = 32'hCAFEF00D;
            end
            pclken = (k % 2 == 0) || (k == 7);
            chk($sformatf("clken_c%0d", k), 64'({psel, penable, hreadyout, hresp}), 64'(clk_exp[k]));
            if (k >= 3 && k <= 6)
                chk($sformatf("clken_data_c%0d", k), 64'({paddr, pstrb, pwrite, pwdata}),
                    64'({16'h0040, 4'b1100, 1'b1, 32'hCAFEF00D}));
        end
        pclken = 1'b1;

        // ---------------- reset while in ACCESS
        pready = 1'b0;
        addr_phase(1'b1, 16'h0050, 3'd2, 4'b0011);
        step();                                             // WAIT
        bus_idle();
        hwdata = 32'h77777777;
        step();                                             // SETUP
        step();                                             // ACCESS
        chk("rstacc_pre", 64'({psel, penable, hreadyout}), 64'b110);
        #2 hreset = 1'b1;
        #1;
        chk("rstacc_async", 64'({psel, penable, hreadyout, hresp}), 64'b0010);
        chk("rstacc_paddr", 64'(paddr), 64'd0);
        #2 hreset = 1'b0;
        pready = 1'b1;
        step();
        do_xfer("post_rst", vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
